// File: rtl/i2c_sda_tx.sv
// Slave-side I2C SDA transmitter: shifts read bytes out MSB first, samples the
// master ACK/NACK, or drives the slave ACK bit. Optional macro I2C_SDA_HOLD_EN.
module i2c_sda_tx #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       past_scl_in,
  input  logic       sda_in,
  input  logic       stop_det,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ack_req,
  output logic       sda_oe,
  output logic       busy,
  output logic       master_ack,
  output logic       master_ack_valid,
  output logic       ack_done
);

  typedef enum logic [2:0] {
    IDLE, TX_WAIT, TX_BIT, MACK_SAMPLE, MACK_END, ACK_WAIT, ACK_DRIVE
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       oe_upd, oe_on_fall, oe_val;
  logic       mack_nxt, mack_vld_nxt, ack_done_nxt;
  logic       fall, rise;

  assign fall = past_scl_in & ~scl_in;
  assign rise = ~past_scl_in & scl_in;

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    oe_upd       = 1'b0;
    oe_on_fall   = 1'b0;
    oe_val       = sda_oe;
    mack_nxt     = master_ack;
    mack_vld_nxt = 1'b0;
    ack_done_nxt = 1'b0;
    if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd7;
      oe_upd      = 1'b1;
      oe_val      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ack_req) begin
            state_nxt = ACK_WAIT;
          end else if (tx_valid) begin
            shreg_nxt   = tx_byte;
            bit_cnt_nxt = 3'd7;
            // SCL already low: the first data bit can go out immediately
            if (!scl_in) begin
              state_nxt = TX_BIT;
              oe_upd    = 1'b1;
              oe_val    = ~tx_byte[7];
            end else begin
              state_nxt = TX_WAIT;
            end
          end
        end
        TX_WAIT: if (fall) begin
          state_nxt  = TX_BIT;
          oe_upd     = 1'b1;
          oe_on_fall = 1'b1;
          oe_val     = ~shreg[7];
        end
        TX_BIT: if (fall) begin
          oe_upd     = 1'b1;
          oe_on_fall = 1'b1;
          if (bit_cnt != 3'd0) begin
            shreg_nxt   = {shreg[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 3'd1;
            oe_val      = ~shreg[6];
          end else begin
            oe_val    = 1'b0;
            state_nxt = MACK_SAMPLE;
          end
        end
        MACK_SAMPLE: if (rise) begin
          mack_nxt     = ~sda_in;
          mack_vld_nxt = 1'b1;
          state_nxt    = MACK_END;
        end
        MACK_END: if (fall) state_nxt = IDLE;
        ACK_WAIT: if (fall) begin
          oe_upd     = 1'b1;
          oe_on_fall = 1'b1;
          oe_val     = 1'b1;
          state_nxt  = ACK_DRIVE;
        end
        ACK_DRIVE: if (fall) begin
          oe_upd       = 1'b1;
          oe_on_fall   = 1'b1;
          oe_val       = 1'b0;
          ack_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bit_cnt          <= 3'd7;
      shreg            <= '0;
      tx_ready         <= 1'b1;
      busy             <= 1'b0;
      master_ack       <= 1'b0;
      master_ack_valid <= 1'b0;
      ack_done         <= 1'b0;
    end else begin
      state            <= state_nxt;
      bit_cnt          <= bit_cnt_nxt;
      shreg            <= shreg_nxt;
      tx_ready         <= (state_nxt == IDLE);
      busy             <= (state_nxt != IDLE);
      master_ack       <= mack_nxt;
      master_ack_valid <= mack_vld_nxt;
      ack_done         <= ack_done_nxt;
    end
  end

`ifdef I2C_SDA_HOLD_EN
  logic [3:0] hold_cnt;
  logic       oe_pend;

  // Fall-triggered changes wait HOLD_CYCLES clocks; any other update
  // (accept, stop_det) is immediate and cancels a pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe   <= 1'b0;
      hold_cnt <= '0;
      oe_pend  <= 1'b0;
    end else if (oe_upd && oe_on_fall) begin
      hold_cnt <= HOLD_LOAD;
      oe_pend  <= oe_val;
    end else if (oe_upd) begin
      sda_oe   <= oe_val;
      hold_cnt <= '0;
    end else if (hold_cnt != 4'd0) begin
      hold_cnt <= hold_cnt - 4'd1;
      if (hold_cnt == 4'd1) sda_oe <= oe_pend;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^{HOLD_LOAD, oe_on_fall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sda_oe <= 1'b0;
    else if (oe_upd) sda_oe <= oe_val;
  end
`endif

endmodule

// File: tb/tb_i2c_sda_tx.sv
// Directed bench for i2c_sda_tx: table of byte transactions plus hand-written
// sequences for slave ACK, stop_det abort, edge-to-SDA latency and async reset.
module tb_i2c_sda_tx;

`ifdef I2C_SDA_HOLD_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       past_scl = 1'b1;
  logic       sda_in = 1'b1;
  logic       stop_det = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ack_req = 1'b0;
  logic       tx_ready, sda_oe, busy, master_ack, master_ack_valid, ack_done;

  int errors = 0;
  int checks = 0;
  int mav_cnt = 0;
  int ad_cnt = 0;

  i2c_sda_tx #(.HOLD_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .past_scl_in(past_scl),
    .sda_in(sda_in), .stop_det(stop_det), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .ack_req(ack_req),
    .sda_oe(sda_oe), .busy(busy), .master_ack(master_ack),
    .master_ack_valid(master_ack_valid), .ack_done(ack_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) past_scl <= scl;
  always @(negedge clk) if (master_ack_valid === 1'b1) mav_cnt <= mav_cnt + 1;
  always @(negedge clk) if (ack_done === 1'b1) ad_cnt <= ad_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // High phase of one SCL period: returns the sda_oe level and whether it held.
  task automatic scl_high(output logic v, output logic stable);
    scl = 1'b1;
    tick();
    v = sda_oe;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (sda_oe !== v) stable = 1'b0;
    end
  endtask

  task automatic run_tx(input string nm, input logic [7:0] b, input logic mlow,
                        input logic [7:0] pat, input logic exp_ack);
    int mav0;
    logic v, st, all_st, oe9, st9;
    logic [7:0] got;
    mav0 = mav_cnt;
    all_st = 1'b1;
    got = '0;
    chk({nm, " tx_ready before"}, tx_ready, 1);
    tx_byte = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk({nm, " busy after accept"}, busy, 1);
    repeat (5) tick();
    for (int i = 0; i < 8; i++) begin
      scl_high(v, st);
      got = {got[6:0], v};
      all_st &= st;
      scl = 1'b0;
      repeat (6) tick();
    end
    sda_in = ~mlow;
    scl_high(oe9, st9);
    sda_in = 1'b1;
    scl = 1'b0;
    repeat (6) tick();
    chk({nm, " data sda_oe"}, got, pat);
    chk({nm, " stable in high"}, all_st, 1);
    chk({nm, " 9th bit released"}, {oe9, st9}, 2'b01);
    chk({nm, " master_ack"}, master_ack, exp_ack);
    chk({nm, " ack_valid pulses"}, mav_cnt - mav0, 1);
    chk({nm, " tx_ready after"}, tx_ready, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       mlow;
    logic [7:0] pat;
    logic       ack;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic v, st, acc;
    int mav0, ad0;

    vecs[0] = '{8'hA5, 1'b1, 8'b0101_1010, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 8'b1100_0011, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'b0000_0000, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 8'b1111_1111, 1'b0};

    // Reset state
    #12;
    chk("reset sda_oe", sda_oe, 0);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset master_ack", {master_ack, master_ack_valid, ack_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Ten idle SCL clocks, no requests
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scl = 1'b0;
      repeat (3) begin tick(); acc |= sda_oe; end
      scl = 1'b1;
      repeat (3) begin tick(); acc |= sda_oe; end
    end
    chk("idle sda_oe", acc, 0);
    chk("idle busy", busy, 0);
    scl = 1'b0;
    repeat (3) tick();

    for (int k = 0; k < 4; k++)
      run_tx($sformatf("tx%02h", vecs[k].b), vecs[k].b, vecs[k].mlow, vecs[k].pat, vecs[k].ack);

    // Slave ACK for a received byte, ack_req during the 8th SCL high
    for (int i = 0; i < 7; i++) begin
      scl = 1'b1; repeat (6) tick();
      scl = 1'b0; repeat (6) tick();
    end
    scl = 1'b1;
    repeat (2) tick();
    ack_req = 1'b1;
    tick();
    ack_req = 1'b0;
    chk("ack busy", busy, 1);
    chk("ack oe before fall", sda_oe, 0);
    repeat (3) tick();
    scl = 1'b0;
    repeat (LAT - 1) tick();
    chk("ack oe not yet", sda_oe, 0);
    tick();
    chk("ack oe driven", sda_oe, 1);
    repeat (6 - LAT) tick();
    scl_high(v, st);
    chk("ack held in 9th high", {v, st}, 2'b11);
    ad0 = ad_cnt;
    scl = 1'b0;
    repeat (LAT) tick();
    chk("ack released", sda_oe, 0);
    chk("ack back idle", busy, 0);
    repeat (4) tick();
    chk("ack_done pulses", ad_cnt - ad0, 1);

    // stop_det aborts 0x00 during the 4th bit
    mav0 = mav_cnt;
    tx_byte = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      scl = 1'b1; repeat (6) tick();
      scl = 1'b0; repeat (6) tick();
    end
    scl = 1'b1;
    repeat (2) tick();
    chk("stop oe before", sda_oe, 1);
    stop_det = 1'b1;
    tick();
    stop_det = 1'b0;
    chk("stop oe released", sda_oe, 0);
    chk("stop busy", busy, 0);
    repeat (3) tick();
    scl = 1'b0;
    repeat (6) tick();
    chk("stop no ack_valid", mav_cnt - mav0, 0);
    run_tx("tx81 after stop", 8'h81, 1'b1, 8'b0111_1110, 1'b1);

    // Fall-to-sda_oe latency on 0x80 (bit7 released, bit6 driven)
    tx_byte = 8'h80;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    scl_high(v, st);
    chk("lat bit7 released", {v, st}, 2'b01);
    scl = 1'b0;
    repeat (LAT - 1) tick();
    chk("lat oe unchanged", sda_oe, 0);
    tick();
    chk("lat oe changed", sda_oe, 1);
    repeat (6 - LAT) tick();
    scl_high(v, st);
    chk("lat bit6 stable", {v, st}, 2'b11);
    stop_det = 1'b1;
    tick();
    stop_det = 1'b0;
    scl = 1'b0;
    tick();
    chk("lat stop idle", {busy, sda_oe}, 0);
    repeat (5) tick();

    // Asynchronous reset mid-byte releases SDA without a clock edge
    tx_byte = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    chk("areset oe before", sda_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset oe released", sda_oe, 0);
    chk("areset idle", {busy, tx_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
